// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int          DEF_IP_WIDTH   = 8;
    localparam int          DEF_LINE_WIDTH = 32;
    localparam logic [31:0] DEF_HALT_WORD  = 32'hFFFF_FFFF;

    // IDLE: waiting for start; FETCH: one-cycle memory read;
    // ISSUE: instruction offered to execute; HALT: program ended.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_ip_counter.sv
// Instruction-pointer register: clear, load or increment (wrapping).
// Priority: rst > clr > load > inc.
module ip_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Update the pointer; the +1 wraps naturally at the register width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= ld_val;
        end else if (inc) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the IP, reads one line per FETCH,
// presents it on instr/instr_valid and applies jump redirects.
//
// Handshake: instr is transferred on a clk edge where instr_valid=1 and
// instr_ready=1; instr and instr_valid stay stable until that edge, and
// instr_ready while instr_valid=0 has no effect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                    IP_WIDTH   = DEF_IP_WIDTH,
    parameter int                    LINE_WIDTH = DEF_LINE_WIDTH,
    parameter logic [LINE_WIDTH-1:0] HALT_WORD  = DEF_HALT_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_en,
    output logic [IP_WIDTH-1:0]   mem_ip,
    input  logic [LINE_WIDTH-1:0] mem_line,
    output logic [LINE_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump_en,
    input  logic [IP_WIDTH-1:0]   jump_target,
    output logic [IP_WIDTH-1:0]   cur_ip,
    output logic                  busy,
    output logic                  halted,
    output fetch_state_t          dbg_state
);

    fetch_state_t            r_state;
    logic [LINE_WIDTH-1:0]   r_instr;
    logic                    r_instr_valid;
    logic                    r_mem_en;
    logic                    r_busy;
    logic                    r_halted;

    logic                    w_hs;
    logic                    w_clr;
    logic                    w_load;
    logic                    w_inc;
    logic [IP_WIDTH-1:0]     w_ip;

    // The transfer edge; jump_en only matters here.
    assign w_hs   = (r_state == ISSUE) && r_instr_valid && instr_ready;
    assign w_clr  = start && ((r_state == IDLE) || (r_state == HALT));
    assign w_load = w_hs && jump_en;
    assign w_inc  = w_hs && !jump_en;

    ip_counter #(
        .W (IP_WIDTH)
    ) u_ip (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .inc    (w_inc),
        .load   (w_load),
        .ld_val (jump_target),
        .q      (w_ip)
    );

    // Sequencer FSM; status outputs are registered alongside the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_mem_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= FETCH;
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                FETCH: begin
                    r_mem_en <= 1'b0;
                    if (mem_line == HALT_WORD) begin
                        r_state  <= HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_instr       <= mem_line;
                        r_instr_valid <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_hs) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= FETCH;
                        r_mem_en      <= 1'b1;
                    end
                end
                HALT: begin
                    if (start) begin
                        r_state  <= FETCH;
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_ip      = w_ip;
    assign cur_ip      = w_ip;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: behavioural line memory, expected-instruction
// queue popped on every transfer, directed scenarios per feature.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int IPW = 8;
  localparam int LW  = 32;
  localparam logic [LW-1:0] HALTW = 32'hFFFF_FFFF;

  logic           clk;
  logic           rst;
  logic           start;
  logic           mem_en;
  logic [IPW-1:0] mem_ip;
  logic [LW-1:0]  mem_line;
  logic [LW-1:0]  instr;
  logic           instr_valid;
  logic           instr_ready;
  logic           jump_en;
  logic [IPW-1:0] jump_target;
  logic [IPW-1:0] cur_ip;
  logic           busy;
  logic           halted;
  fetch_state_t   dbg_state;

  logic [LW-1:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pop = 0;
  int prev_pop = 0;

  logic [IPW+LW-1:0] exp_q[$];

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_en      (mem_en),
    .mem_ip      (mem_ip),
    .mem_line    (mem_line),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .cur_ip      (cur_ip),
    .busy        (busy),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_line = mem_en ? mem[mem_ip] : 32'h0BAD_0BAD;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  // scoreboard: every transfer must match the oldest expected {ip, line}
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr", {32'h0, instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [IPW+LW-1:0] e;
        e = exp_q.pop_front();
        chk("instr", 64'(instr), 64'(e[LW-1:0]));
        chk("cur_ip", 64'(cur_ip), 64'(e[IPW+LW-1:LW]));
      end
      prev_pop = last_pop;
      last_pop = cyc;
    end
  end

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + 32'(i);
  endtask

  task automatic push_exp(input logic [IPW-1:0] ip, input logic [LW-1:0] line);
    exp_q.push_back({ip, line});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      step();
    end
    chk("wait_valid", 64'(instr_valid), 64'd1);
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 40; i++) begin
      if (halted) break;
      step();
    end
    chk("wait_halted", 64'(halted), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mem_en_after_halt", 64'(mem_en), 64'd0);
    end
  endtask

  // one transfer with optional redirect, then back to ready=0
  task automatic handshake(input logic jmp, input logic [IPW-1:0] tgt);
    wait_valid();
    jump_en     = jmp;
    jump_target = tgt;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    jump_en     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    jump_en = 1'b0; jump_target = '0;
    clear_mem();
    repeat (3) step();

    // reset state
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ip", 64'(cur_ip), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    step();
    chk("idle_no_fetch", 64'(mem_en), 64'd0);

    // sequential fetch at full throughput
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = HALTW;
    push_exp(8'h00, 32'h11);
    push_exp(8'h01, 32'h22);
    instr_ready = 1'b1;
    pulse_start();
    chk("fetch_after_start", 64'(mem_en), 64'd1);
    wait_halted();
    chk("issue_spacing", 64'(last_pop - prev_pop), 64'd2);
    chk("halt_busy", 64'(busy), 64'd0);
    instr_ready = 1'b0;

    // restart from HALT, back-pressure, start ignored in ISSUE
    mem[0] = 32'h33; mem[1] = 32'h44; mem[2] = HALTW;
    push_exp(8'h00, 32'h33);
    push_exp(8'h01, 32'h44);
    pulse_start();
    chk("restart_halted", 64'(halted), 64'd0);
    chk("restart_mem_en", 64'(mem_en), 64'd1);
    chk("restart_ip", 64'(cur_ip), 64'd0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      chk("bp_instr", 64'(instr), 64'h33);
      chk("bp_ip", 64'(cur_ip), 64'd0);
      chk("bp_valid", 64'(instr_valid), 64'd1);
      chk("bp_mem_en", 64'(mem_en), 64'd0);
    end
    start = 1'b0;
    chk("start_in_issue", 64'(dbg_state), 64'(ISSUE));
    handshake(1'b0, 8'h00);
    wait_valid();
    chk("ip_advanced", 64'(cur_ip), 64'd1);
    handshake(1'b0, 8'h00);
    wait_halted();

    // jump redirect; jump_en outside a transfer has no effect
    clear_mem();
    mem[0] = 32'h11; mem[1] = 32'h22; mem[8'h40] = 32'hAB; mem[8'h41] = HALTW;
    push_exp(8'h00, 32'h11);
    push_exp(8'h01, 32'h22);
    push_exp(8'h40, 32'hAB);
    pulse_start();
    wait_valid();
    jump_en = 1'b1; jump_target = 8'h40;
    step();
    jump_en = 1'b0;
    chk("jump_no_hs_ip", 64'(cur_ip), 64'd0);
    handshake(1'b0, 8'h00);
    jump_en = 1'b1; jump_target = 8'h40;
    step();
    jump_en = 1'b0;
    chk("jump_in_fetch_ip", 64'(cur_ip), 64'd1);
    handshake(1'b1, 8'h40);
    handshake(1'b0, 8'h00);
    wait_halted();
    chk("jump_halt_ip", 64'(cur_ip), 64'h41);

    // wrap from 0xFF to 0
    clear_mem();
    mem[0] = 32'h7; mem[8'hFF] = 32'h5; mem[8'h10] = HALTW;
    push_exp(8'h00, 32'h7);
    push_exp(8'hFF, 32'h5);
    push_exp(8'h00, 32'h7);
    pulse_start();
    handshake(1'b1, 8'hFF);
    handshake(1'b0, 8'h00);
    handshake(1'b1, 8'h10);
    wait_halted();

    // reset while an instruction is pending
    mem[0] = 32'h99;
    pulse_start();
    wait_valid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 64'(instr_valid), 64'd0);
    chk("midrst_instr", 64'(instr), 64'd0);
    chk("midrst_ip", 64'(cur_ip), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'(IDLE));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_fetch", 64'(mem_en), 64'd0);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the line memory. Owns the instruction pointer (IP), drives the memory's enable and address, and captures each returned line into an output register. It presents the captured line to the execute stage over a valid/ready handshake and applies jump redirects. It detects the all-ones halt word and stops fetching.

Parameters:
IP_WIDTH, 8, instruction-pointer width; memory depth is 2^IP_WIDTH lines
LINE_WIDTH, 32, instruction word width
HALT_WORD, 32'hFFFF_FFFF, line value that terminates the program

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin or restart execution from IP 0
mem_en  output  1  line-memory enable
mem_ip  output  IP_WIDTH  line-memory address
mem_line  input  LINE_WIDTH  line-memory read data, combinational from mem_ip while mem_en=1
instr  output  LINE_WIDTH  registered instruction presented to execute
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  execute accepts instr this cycle
jump_en  input  1  redirect request; qualified by the handshake
jump_target  input  IP_WIDTH  redirect address
cur_ip  output  IP_WIDTH  IP of the line currently in instr
busy  output  1  state is FETCH or ISSUE
halted  output  1  HALT_WORD reached

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything, including mid-operation:
  - state=IDLE, ip=0, instr=0, instr_valid=0, halted=0, mem_en=0.
  - A pending instr_valid drops on the next edge.
- Address and status outputs:
  - mem_ip=ip at all times.
  - cur_ip=ip.
  - mem_en=1 only in FETCH.
  - busy=1 in FETCH or ISSUE.
  - halted=1 only in HALT.
- IDLE: start=1 -> FETCH with ip=0. Otherwise stay in IDLE.
- FETCH (exactly one cycle):
  - mem_line is sampled at the end of the cycle.
  - If mem_line==HALT_WORD: go to HALT. instr is unchanged and instr_valid stays 0.
  - Otherwise: instr<=mem_line, instr_valid<=1, go to ISSUE.
- ISSUE:
  - instr and instr_valid are held stable until instr_valid & instr_ready.
  - On the handshake edge, instr_valid<=0 and the state goes to FETCH.
  - If jump_en=1 in the same cycle: ip<=jump_target. Otherwise ip<=ip+1, wrapping modulo 2^IP_WIDTH (all-ones -> 0).
  - jump_en is ignored in every other cycle and state.
- HALT:
  - No memory access; instr_valid=0.
  - start=1 -> FETCH with ip=0, halted cleared on the same edge.
- start is ignored in FETCH and ISSUE.
- Latency and throughput:
  - start edge to instr_valid=1 is 2 edges.
  - Maximum throughput is one instruction per 2 cycles with instr_ready held high.
- Simultaneous events:
  - rst beats start, the handshake and jump_en.
  - A jump to the current ip is legal and refetches the same line.
- instr_ready while instr_valid=0 has no effect.

Decomposition:
- Shared package params.svh:
  - IP_WIDTH, LINE_WIDTH, HALT_WORD.
  - typedef enum logic [1:0] fetch_state_t {IDLE, FETCH, ISSUE, HALT}.
- One sub-module, ip_counter: a synchronous-reset IP register with ports clk, rst, clr (to 0), inc (+1 with wrap), load (with ld_val) and q.
  - Priority order: rst > clr > load > inc.
- fetch_ctrl keeps the FSM and the instr register.

Test Plan:
- Sequential fetch: memory [0]=32'h11, [1]=32'h22, [2]=HALT_WORD; pulse start, instr_ready=1 -> expected response:
  - instr 32'h11 at cur_ip 0, then 32'h22 at cur_ip 1, each with valid one cycle, two cycles apart.
  - halted=1 after the third fetch; mem_en never asserted afterward.
- Back-pressure: instr_ready=0 for 5 cycles after valid -> instr, cur_ip and instr_valid are held constant; ip does not advance; mem_en=0 throughout.
- Jump: at the handshake on ip=1, drive jump_en=1 and jump_target=8'h40 (memory [0x40]=32'hAB) -> next instr=32'hAB with cur_ip=8'h40. jump_en pulsed outside a handshake -> no effect.
- Wrap: IP_WIDTH=8, jump to 8'hFF, memory [0xFF]=32'h5, [0x00]=32'h7; handshake -> next fetch at ip 0 returns 32'h7.
- Reset mid-ISSUE: rst=1 for one cycle while instr_valid=1 -> next edge gives instr_valid=0, instr=0, ip=0, state IDLE. No fetch occurs until start.
- Restart from HALT: start=1 while halted -> halted=0 and fetch resumes at ip 0. start during ISSUE -> ignored.
